spi_slave_sync: RTL and testbench
=================================

Name: spi_slave_sync

Overview:
Parametrised, system-clock-domain SPI slave. It is the successor to the SPI_Clk-driven slave: the whole block runs on Clk_i, with SPI pins oversampled through synchronisers. It adds configurable word width, bit order and CS polarity, with all four SPI modes selected at runtime. It also adds a valid/ready TX buffer, an RX hold register and overrun/underrun reporting. It sits between the external SPI pins and the core register/FIFO logic.

Parameters:
DATA_W, 8, word width in bits (≥2).
LSB_FIRST, 0, 0 = MSB shifted first on both MOSI and MISO; 1 = LSB first.
CS_ACTIVE, 1, CS_i level meaning "selected".
SYNC_STAGES, 2, flip-flop stages on SPI_Clk_i, CS_i and MOSI_i (≥2).

Ports:
Clk_i  in  1  system clock; all state is on its rising edge.
rst_n_i  in  1  asynchronous, active-low reset.
SPI_MODE_i  in  2  [1] = CPOL, [0] = CPHA; latched at CS assertion.
SPI_Clk_i  in  1  SPI clock pin (asynchronous).
CS_i  in  1  chip select pin (asynchronous).
MOSI_i  in  1  master-out data pin.
MISO_o  out  1  slave-out data; 0 when not driving.
MISO_OE_o  out  1  MISO output enable; the tristate buffer lives at top level.
TX_DT_i  in  DATA_W  next word to transmit.
TX_VALID_i  in  1  TX_DT_i is valid.
TX_READY_o  out  1  TX buffer is empty; the transfer occurs when TX_VALID_i and TX_READY_o are both high.
RX_DT_o  out  DATA_W  last received word.
RX_VALID_o  out  1  RX_DT_o holds an unread word.
RX_READY_i  in  1  consumer accepts RX_DT_o.
RX_OVR_o  out  1  1-cycle pulse: a word completed while RX_VALID_o was still high.
TX_UDR_o  out  1  1-cycle pulse: a word load found the TX buffer empty.
BUSY_o  out  1  frame active (state ACTIVE).

Behaviour:
- Reset values (rst_n_i low): MISO_o=0, MISO_OE_o=0, TX_READY_o=1, RX_DT_o=0, RX_VALID_o=0, RX_OVR_o=0, TX_UDR_o=0, BUSY_o=0. Also cleared: synchronisers, bit counter, shift registers, latched mode, state=IDLE.
- Synchronisation: SPI_Clk_i, CS_i and MOSI_i each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised SCLK against its previous value.
- Clock ratio: supported when f_SCLK ≤ f_Clk/8; behaviour above this is undefined.
- Edge roles: the leading edge is rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- FSM states:
  - IDLE:
    - Sync CS reaching CS_ACTIVE → ACTIVE.
    - On entry to ACTIVE: latch SPI_MODE_i, clear the bit counter, load the TX word.
    - MISO_OE_o=1.
    - If CPHA=0, MISO_o is set to the first bit of the loaded word in the same cycle.
  - ACTIVE:
    - Sync CS leaving CS_ACTIVE → IDLE in the next cycle.
    - MISO_OE_o=0 and MISO_o=0.
    - Any partial RX word is discarded with no RX_VALID_o and no RX_OVR_o.
    - The partial TX word is dropped and not re-sent.
    - The TX buffer is left untouched.
- TX word load:
  - If the buffer is full, copy it to the TX shift register, empty the buffer and raise TX_READY_o in the next cycle.
  - If the buffer is empty, load all-zero and pulse TX_UDR_o.
  - A TX handshake in the same cycle as a load is not bypassed; it fills the buffer for the following word.
- Sample edge:
  - Shift the synchronised MOSI into the RX shift register in bit order.
  - Increment the bit counter.
  - When the counter is DATA_W-1:
    - Wrap the counter to 0.
    - Next cycle: RX_DT_o ← assembled word and RX_VALID_o=1.
    - If RX_VALID_o was already 1 and RX_READY_i was not asserted in that cycle, overwrite RX_DT_o and pulse RX_OVR_o.
    - In the same cycle, perform a TX word load for the next word.
- Shift edge:
  - CPHA=0: MISO_o ← the next bit of the current word. The shift edge after the last sample outputs the first bit of the newly loaded word.
  - CPHA=1: MISO_o ← the bit at the current counter index.
  - No shift action occurs before the first sample edge when CPHA=0.
- RX handshake: RX_VALID_o clears the cycle after RX_VALID_o & RX_READY_i. If a new word completes in that same cycle, RX_VALID_o stays 1 with the new data and no overrun is flagged.
- Latency: RX_VALID_o rises SYNC_STAGES+2 Clk cycles after the final sample edge at the pin.
- Mode changes: changes on SPI_MODE_i during ACTIVE are ignored until the next frame.
- Reset mid-frame: immediate return to reset values; the first frame after reset is the first CS assertion seen after rst_n_i rises.
- Frame length: back-to-back words in one CS frame are unlimited in number.

Test Plan:
1. Mode 0, DATA_W=8, MSB-first: TX buffer 0xA5, master sends 0x3C → RX_DT_o=0x3C, RX_VALID_o pulse, master receives 0xA5, no RX_OVR_o/TX_UDR_o.
2. All four modes in turn, each exchanging 0x81 and 0x7E in both directions → correct data on both sides; a mode change mid-frame has no effect.
3. Two words in one frame with RX_READY_i held low → second word 0x55 overwrites, RX_OVR_o pulses once, RX_DT_o=0x55.
4. Empty TX buffer at frame start → TX_UDR_o pulse, master receives 0x00; a TX_VALID_i write of 0xC3 mid-word is sent as the next word.
5. CS deasserted after 5 bits → no RX_VALID_o, MISO_OE_o=0; the next frame sending 0xF0 is received as 0xF0 (counter restarted).
6. DATA_W=12, LSB_FIRST=1, CS_ACTIVE=0: exchange 0xABC/0x123 → bit order and CS polarity correct; rst_n_i pulsed mid-word → all outputs at reset values.

Source files
------------

// File: rtl/spi_slave_sync.sv
// SPI slave clocked entirely by Clk_i: SCLK/CS/MOSI are oversampled through synchronisers.
// Provides a one-word TX buffer (valid/ready), an RX hold register and overrun/underrun pulses.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int LSB_FIRST   = 0,
  parameter int CS_ACTIVE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Clk_i,
  input  logic              rst_n_i,
  input  logic [1:0]        SPI_MODE_i,
  input  logic              SPI_Clk_i,
  input  logic              CS_i,
  input  logic              MOSI_i,
  output logic              MISO_o,
  output logic              MISO_OE_o,
  input  logic [DATA_W-1:0] TX_DT_i,
  input  logic              TX_VALID_i,
  output logic              TX_READY_o,
  output logic [DATA_W-1:0] RX_DT_o,
  output logic              RX_VALID_o,
  input  logic              RX_READY_i,
  output logic              RX_OVR_o,
  output logic              TX_UDR_o,
  output logic              BUSY_o
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic CS_LVL = (CS_ACTIVE != 0) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  function automatic logic word_bit(input logic [DATA_W-1:0] w, input logic [CNT_W-1:0] idx);
    if (LSB_FIRST != 0) return w[idx];
    else return w[LAST_CNT - idx];
  endfunction

  state_t state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic sclk_prev_r;
  logic [1:0] mode_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic sampled_r, word_done_r, miso_r, miso_oe_r;
  logic [DATA_W-1:0] rx_shift_r, tx_word_r, tx_buf_r, rx_dt_r;
  logic tx_empty_r, tx_udr_r, rx_valid_r, rx_ovr_r;
  logic sclk_s, cs_act_s, mosi_s, rise_s, fall_s, lead_s, trail_s;
  logic enter_s, leave_s, active_s, sample_s, shift_s, last_s, load_s;
  logic [DATA_W-1:0] load_word_s;

  // Pin synchronisers; CS resets to its inactive level so reset release never looks like a select.
  always_ff @(posedge Clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{~CS_LVL}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SPI_Clk_i};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS_i};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI_i};
      sclk_prev_r <= sclk_s;
    end
  end

  assign sclk_s   = sclk_sync_r[SYNC_STAGES-1];
  assign cs_act_s = (cs_sync_r[SYNC_STAGES-1] == CS_LVL);
  assign mosi_s   = mosi_sync_r[SYNC_STAGES-1];
  assign rise_s   = sclk_s & ~sclk_prev_r;
  assign fall_s   = ~sclk_s & sclk_prev_r;
  assign lead_s   = mode_r[1] ? fall_s : rise_s;
  assign trail_s  = mode_r[1] ? rise_s : fall_s;

  // State register.
  always_ff @(posedge Clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_r <= ST_IDLE;
    else state_r <= state_nxt_s;
  end

  // Next-state logic with frame entry/exit strobes.
  always_comb begin
    state_nxt_s = state_r;
    enter_s     = 1'b0;
    leave_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_act_s) begin
          state_nxt_s = ST_ACTIVE;
          enter_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!cs_act_s) begin
          state_nxt_s = ST_IDLE;
          leave_s     = 1'b1;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // With CPHA=0 the first shift edge is ignored until a bit has been sampled.
  assign active_s    = (state_r == ST_ACTIVE) & cs_act_s;
  assign sample_s    = active_s & (mode_r[0] ? trail_s : lead_s);
  assign shift_s     = active_s & (mode_r[0] ? lead_s : (trail_s & sampled_r));
  assign last_s      = sample_s & (bit_cnt_r == LAST_CNT);
  assign load_s      = enter_s | last_s;
  assign load_word_s = tx_empty_r ? {DATA_W{1'b0}} : tx_buf_r;

  // Frame datapath: mode latch, bit counter, RX shifter and MISO driver.
  always_ff @(posedge Clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_r      <= 2'b00;
      bit_cnt_r   <= {CNT_W{1'b0}};
      sampled_r   <= 1'b0;
      word_done_r <= 1'b0;
      rx_shift_r  <= {DATA_W{1'b0}};
      tx_word_r   <= {DATA_W{1'b0}};
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
    end else begin
      word_done_r <= last_s;
      if (enter_s) begin
        mode_r    <= SPI_MODE_i;
        bit_cnt_r <= {CNT_W{1'b0}};
        sampled_r <= 1'b0;
        tx_word_r <= load_word_s;
        miso_oe_r <= 1'b1;
        miso_r    <= SPI_MODE_i[0] ? 1'b0 : word_bit(load_word_s, {CNT_W{1'b0}});
      end else if (leave_s) begin
        bit_cnt_r <= {CNT_W{1'b0}};
        sampled_r <= 1'b0;
        miso_oe_r <= 1'b0;
        miso_r    <= 1'b0;
      end else if (sample_s) begin
        rx_shift_r <= (LSB_FIRST != 0) ? {mosi_s, rx_shift_r[DATA_W-1:1]}
                                       : {rx_shift_r[DATA_W-2:0], mosi_s};
        sampled_r  <= 1'b1;
        if (last_s) begin
          bit_cnt_r <= {CNT_W{1'b0}};
          tx_word_r <= load_word_s;
        end else begin
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
      end else if (shift_s) begin
        miso_r <= word_bit(tx_word_r, bit_cnt_r);
      end
    end
  end

  // One-word TX buffer; a load takes priority, so a same-cycle handshake fills it for the next word.
  always_ff @(posedge Clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_buf_r   <= {DATA_W{1'b0}};
      tx_empty_r <= 1'b1;
      tx_udr_r   <= 1'b0;
    end else begin
      tx_udr_r <= load_s & tx_empty_r;
      if (load_s && !tx_empty_r) begin
        tx_empty_r <= 1'b1;
      end else if (TX_VALID_i && tx_empty_r) begin
        tx_buf_r   <= TX_DT_i;
        tx_empty_r <= 1'b0;
      end else begin
        tx_empty_r <= tx_empty_r;
      end
    end
  end

  // RX hold register: a completed word always lands, flagging overrun if the old one was unread.
  always_ff @(posedge Clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_dt_r    <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
      rx_ovr_r   <= 1'b0;
    end else begin
      rx_ovr_r <= word_done_r & rx_valid_r & ~RX_READY_i;
      if (word_done_r) begin
        rx_dt_r    <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rx_valid_r && RX_READY_i) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
    end
  end

  assign MISO_o     = miso_r;
  assign MISO_OE_o  = miso_oe_r;
  assign TX_READY_o = tx_empty_r;
  assign RX_DT_o    = rx_dt_r;
  assign RX_VALID_o = rx_valid_r;
  assign RX_OVR_o   = rx_ovr_r;
  assign TX_UDR_o   = tx_udr_r;
  assign BUSY_o     = (state_r == ST_ACTIVE);
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: an 8-bit MSB-first instance and a 12-bit LSB-first, active-low-CS
// instance share SCLK/MOSI; expectations come from a word-level TX queue model and the words sent.
`timescale 1ns/1ps
module tb_spi_slave_sync;
  localparam int HALF = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sclk, mosi, cs_a, cs_b;
  logic [1:0] spi_mode;
  logic [7:0] tx_dt_a, rx_dt_a;
  logic [11:0] tx_dt_b, rx_dt_b;
  logic tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, rx_ovr_a, tx_udr_a, busy_a, miso_a, miso_oe_a;
  logic tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, rx_ovr_b, tx_udr_b, busy_b, miso_b, miso_oe_b;

  spi_slave_sync dut_a (
    .Clk_i(clk), .rst_n_i(rst_n), .SPI_MODE_i(spi_mode), .SPI_Clk_i(sclk), .CS_i(cs_a),
    .MOSI_i(mosi), .MISO_o(miso_a), .MISO_OE_o(miso_oe_a), .TX_DT_i(tx_dt_a),
    .TX_VALID_i(tx_valid_a), .TX_READY_o(tx_ready_a), .RX_DT_o(rx_dt_a), .RX_VALID_o(rx_valid_a),
    .RX_READY_i(rx_ready_a), .RX_OVR_o(rx_ovr_a), .TX_UDR_o(tx_udr_a), .BUSY_o(busy_a));

  spi_slave_sync #(.DATA_W(12), .LSB_FIRST(1), .CS_ACTIVE(0), .SYNC_STAGES(2)) dut_b (
    .Clk_i(clk), .rst_n_i(rst_n), .SPI_MODE_i(spi_mode), .SPI_Clk_i(sclk), .CS_i(cs_b),
    .MOSI_i(mosi), .MISO_o(miso_b), .MISO_OE_o(miso_oe_b), .TX_DT_i(tx_dt_b),
    .TX_VALID_i(tx_valid_b), .TX_READY_o(tx_ready_b), .RX_DT_o(rx_dt_b), .RX_VALID_o(rx_valid_b),
    .RX_READY_i(rx_ready_b), .RX_OVR_o(rx_ovr_b), .TX_UDR_o(tx_udr_b), .BUSY_o(busy_b));

  int tests_run = 0, tests_failed = 0;
  int ovr_a = 0, udr_a = 0, ovr_b = 0, udr_b = 0;
  int exp_udr_a = 0, exp_udr_b = 0;
  logic [15:0] rxq_a[$], rxq_b[$], txq_a[$], txq_b[$];

  // Pulse counters and log of RX words actually handed over to the consumer.
  always @(posedge clk) begin
    if (rx_ovr_a) ovr_a <= ovr_a + 1;
    if (tx_udr_a) udr_a <= udr_a + 1;
    if (rx_ovr_b) ovr_b <= ovr_b + 1;
    if (tx_udr_b) udr_b <= udr_b + 1;
    if (rx_valid_a && rx_ready_a) rxq_a.push_back({8'h00, rx_dt_a});
    if (rx_valid_b && rx_ready_b) rxq_b.push_back({4'h0, rx_dt_b});
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each word load takes the oldest accepted TX word, or all-zero with an underrun.
  task automatic model_load(input int which, output logic [15:0] w);
    if (which == 0) begin
      if (txq_a.size() > 0) w = txq_a.pop_front();
      else begin w = 16'h0000; exp_udr_a++; end
    end else begin
      if (txq_b.size() > 0) w = txq_b.pop_front();
      else begin w = 16'h0000; exp_udr_b++; end
    end
  endtask

  task automatic hc();
    repeat (HALF) @(negedge clk);
  endtask

  function automatic logic cur_miso(input int which);
    return (which == 0) ? miso_a : miso_b;
  endfunction

  function automatic logic cur_ready(input int which);
    return (which == 0) ? tx_ready_a : tx_ready_b;
  endfunction

  task automatic set_cs(input int which, input logic sel);
    if (which == 0) cs_a = sel;
    else cs_b = ~sel;
  endtask

  task automatic frame_begin(input int which, input logic [1:0] mode);
    spi_mode = mode;
    sclk = mode[1];
    hc();
    set_cs(which, 1'b1);
    hc();
    hc();
  endtask

  task automatic frame_end(input int which);
    hc();
    set_cs(which, 1'b0);
    hc();
    hc();
  endtask

  task automatic xfer(input int which, input logic [1:0] mode, input int dw, input int nsend,
                      input logic lsb, input logic [15:0] tx, output logic [15:0] rx);
    rx = 16'h0000;
    for (int i = 0; i < nsend; i++) begin
      int idx;
      idx = lsb ? i : dw - 1 - i;
      if (!mode[0]) begin
        mosi = tx[idx];
        hc();
        rx[idx] = cur_miso(which);
        sclk = ~mode[1];
        hc();
        sclk = mode[1];
      end else begin
        sclk = ~mode[1];
        mosi = tx[idx];
        hc();
        rx[idx] = cur_miso(which);
        sclk = mode[1];
        hc();
      end
    end
  endtask

  task automatic push_tx(input int which, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    if (which == 0) begin tx_dt_a = d[7:0]; tx_valid_a = 1'b1; end
    else begin tx_dt_b = d[11:0]; tx_valid_b = 1'b1; end
    for (int k = 0; k < 400 && !ok; k++) begin
      if (cur_ready(which)) ok = 1'b1;
      @(negedge clk);
    end
    if (which == 0) tx_valid_a = 1'b0;
    else tx_valid_b = 1'b0;
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL push_tx dut%0d: ready never seen, got %b, required 1", which, cur_ready(which));
    end else if (which == 0) txq_a.push_back(d & 16'h00FF);
    else txq_b.push_back(d & 16'h0FFF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({miso_a, miso_oe_a, tx_ready_a, rx_valid_a, rx_ovr_a, tx_udr_a, busy_a} !== 7'b0010000) begin
      tests_failed++;
      $display("FAIL reset_flags_a: got %b, required 0010000",
               {miso_a, miso_oe_a, tx_ready_a, rx_valid_a, rx_ovr_a, tx_udr_a, busy_a});
    end
    tests_run++;
    if (rx_dt_a !== 8'h00) begin tests_failed++; $display("FAIL reset_rxdt_a: got %h, required 00", rx_dt_a); end
    tests_run++;
    if ({miso_b, miso_oe_b, tx_ready_b, rx_valid_b, rx_ovr_b, tx_udr_b, busy_b} !== 7'b0010000) begin
      tests_failed++;
      $display("FAIL reset_flags_b: got %b, required 0010000",
               {miso_b, miso_oe_b, tx_ready_b, rx_valid_b, rx_ovr_b, tx_udr_b, busy_b});
    end
    tests_run++;
    if (rx_dt_b !== 12'h000) begin tests_failed++; $display("FAIL reset_rxdt_b: got %h, required 000", rx_dt_b); end
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if ({busy_a, busy_b} !== 2'b00) begin tests_failed++; $display("FAIL post_reset_busy: got %b, required 00", {busy_a, busy_b}); end
  endtask

  task automatic test_basic();
    logic [15:0] r, e, d;
    logic [1:0] m;
    int u0, eu0, o0;
    u0 = udr_a; eu0 = exp_udr_a; o0 = ovr_a;
    rx_ready_a = 1'b0;
    push_tx(0, 16'h00A5);
    frame_begin(0, 2'b00);
    model_load(0, e);
    tests_run++;
    if ({busy_a, miso_oe_a} !== 2'b11) begin tests_failed++; $display("FAIL basic_active: busy/oe got %b, required 11", {busy_a, miso_oe_a}); end
    push_tx(0, 16'h005A);
    xfer(0, 2'b00, 8, 8, 1'b0, 16'h003C, r);
    model_load(0, d);
    frame_end(0);
    tests_run++;
    if (r !== e) begin tests_failed++; $display("FAIL basic_miso: got %h, required %h", r, e); end
    tests_run++;
    if ({rx_valid_a, rx_dt_a} !== {1'b1, 8'h3C}) begin tests_failed++; $display("FAIL basic_rx: got %b/%h, required 1/3c", rx_valid_a, rx_dt_a); end
    tests_run++;
    if (ovr_a - o0 !== 0 || udr_a - u0 !== exp_udr_a - eu0) begin
      tests_failed++;
      $display("FAIL basic_flags: ovr %0d udr %0d, required 0 and %0d", ovr_a - o0, udr_a - u0, exp_udr_a - eu0);
    end
    tests_run++;
    if ({miso_oe_a, miso_a, busy_a} !== 3'b000) begin tests_failed++; $display("FAIL basic_idle_pins: got %b, required 000", {miso_oe_a, miso_a, busy_a}); end
    rx_ready_a = 1'b1;
    @(negedge clk);
    rx_ready_a = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL basic_rx_consume: got %b, required 0", rx_valid_a); end
    rx_ready_a = 1'b1;
    for (int it = 0; it < 3; it++) begin
      rxq_a.delete();
      m = 2'($urandom_range(0, 3));
      d = 16'($urandom_range(0, 255));
      push_tx(0, 16'($urandom_range(0, 255)));
      frame_begin(0, m);
      model_load(0, e);
      push_tx(0, 16'($urandom_range(0, 255)));
      xfer(0, m, 8, 8, 1'b0, d, r);
      model_load(0, e);
      frame_end(0);
      tests_run++;
      if (rxq_a.size() != 1 || rxq_a[0] !== d) begin
        tests_failed++;
        $display("FAIL rand_rx mode=%0d: got %0d words first %h, required 1 word %h", m, rxq_a.size(), rxq_a[0], d);
      end
    end
  endtask

  task automatic test_modes();
    logic [15:0] r0, r1, e0, e1, e2;
    int u0, eu0;
    rx_ready_a = 1'b1;
    for (int mi = 0; mi < 4; mi++) begin
      logic [1:0] m;
      m = 2'(mi);
      rxq_a.delete();
      u0 = udr_a; eu0 = exp_udr_a;
      push_tx(0, 16'h0081);
      frame_begin(0, m);
      model_load(0, e0);
      spi_mode = m ^ 2'($urandom_range(1, 3));
      push_tx(0, 16'h007E);
      xfer(0, m, 8, 8, 1'b0, 16'h007E, r0);
      model_load(0, e1);
      xfer(0, m, 8, 8, 1'b0, 16'h0081, r1);
      model_load(0, e2);
      frame_end(0);
      tests_run++;
      if (r0 !== e0 || r1 !== e1) begin tests_failed++; $display("FAIL mode%0d_miso: got %h %h, required %h %h", mi, r0, r1, e0, e1); end
      tests_run++;
      if (rxq_a.size() != 2 || rxq_a[0] !== 16'h007E || rxq_a[1] !== 16'h0081) begin
        tests_failed++;
        $display("FAIL mode%0d_rx: got %0d words %h %h, required 2 words 7e 81", mi, rxq_a.size(), rxq_a[0], rxq_a[1]);
      end
      tests_run++;
      if (udr_a - u0 !== exp_udr_a - eu0) begin tests_failed++; $display("FAIL mode%0d_udr: got %0d, required %0d", mi, udr_a - u0, exp_udr_a - eu0); end
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [15:0] r, e;
    int o0;
    o0 = ovr_a;
    rx_ready_a = 1'b0;
    push_tx(0, 16'($urandom_range(0, 255)));
    frame_begin(0, 2'b00);
    model_load(0, e);
    xfer(0, 2'b00, 8, 8, 1'b0, 16'h00AA, r);
    model_load(0, e);
    xfer(0, 2'b00, 8, 8, 1'b0, 16'h0055, r);
    model_load(0, e);
    frame_end(0);
    tests_run++;
    if ({rx_valid_a, rx_dt_a} !== {1'b1, 8'h55}) begin tests_failed++; $display("FAIL ovr_rx: got %b/%h, required 1/55", rx_valid_a, rx_dt_a); end
    tests_run++;
    if (ovr_a - o0 !== 1) begin tests_failed++; $display("FAIL ovr_count: got %0d, required 1", ovr_a - o0); end
    rx_ready_a = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underrun();
    logic [15:0] r0, r1, e0, e1, e2, d;
    int u0, eu0;
    rx_ready_a = 1'b1;
    u0 = udr_a; eu0 = exp_udr_a;
    d = 16'($urandom_range(0, 255));
    frame_begin(0, 2'b00);
    model_load(0, e0);
    fork
      xfer(0, 2'b00, 8, 8, 1'b0, d, r0);
      begin repeat (HALF * 6) @(negedge clk); push_tx(0, 16'h00C3); end
    join
    model_load(0, e1);
    xfer(0, 2'b00, 8, 8, 1'b0, ~d & 16'h00FF, r1);
    model_load(0, e2);
    frame_end(0);
    tests_run++;
    if (r0 !== e0 || r1 !== e1) begin tests_failed++; $display("FAIL udr_miso: got %h %h, required %h %h", r0, r1, e0, e1); end
    tests_run++;
    if (udr_a - u0 !== exp_udr_a - eu0) begin tests_failed++; $display("FAIL udr_count: got %0d, required %0d", udr_a - u0, exp_udr_a - eu0); end
  endtask

  task automatic test_abort();
    logic [15:0] r, e;
    rx_ready_a = 1'b1;
    rxq_a.delete();
    push_tx(0, 16'($urandom_range(0, 255)));
    frame_begin(0, 2'b01);
    model_load(0, e);
    xfer(0, 2'b01, 8, 5, 1'b0, 16'h00FF, r);
    frame_end(0);
    tests_run++;
    if (rxq_a.size() != 0 || rx_valid_a !== 1'b0) begin tests_failed++; $display("FAIL abort_rx: got %0d words valid %b, required 0 and 0", rxq_a.size(), rx_valid_a); end
    tests_run++;
    if ({miso_oe_a, miso_a} !== 2'b00) begin tests_failed++; $display("FAIL abort_pins: got %b, required 00", {miso_oe_a, miso_a}); end
    push_tx(0, 16'($urandom_range(0, 255)));
    frame_begin(0, 2'b01);
    model_load(0, e);
    xfer(0, 2'b01, 8, 8, 1'b0, 16'h00F0, r);
    model_load(0, e);
    frame_end(0);
    tests_run++;
    if (rxq_a.size() != 1 || rxq_a[0] !== 16'h00F0) begin tests_failed++; $display("FAIL abort_next_rx: got %0d words %h, required 1 word f0", rxq_a.size(), rxq_a[0]); end
  endtask

  task automatic test_wide_lsb();
    logic [15:0] r, e, d;
    logic [1:0] m;
    rx_ready_b = 1'b1;
    for (int it = 0; it < 3; it++) begin
      rxq_b.delete();
      m = 2'($urandom_range(0, 3));
      d = (it == 0) ? 16'h0123 : 16'($urandom_range(0, 4095));
      push_tx(1, (it == 0) ? 16'h0ABC : 16'($urandom_range(0, 4095)));
      frame_begin(1, m);
      model_load(1, e);
      tests_run++;
      if ({busy_b, busy_a} !== 2'b10) begin tests_failed++; $display("FAIL wide_cs_pol: busy b/a got %b, required 10", {busy_b, busy_a}); end
      xfer(1, m, 12, 12, 1'b1, d, r);
      frame_end(1);
      tests_run++;
      if (r !== e) begin tests_failed++; $display("FAIL wide_miso mode=%0d: got %h, required %h", m, r, e); end
      tests_run++;
      if (rxq_b.size() != 1 || rxq_b[0] !== d) begin tests_failed++; $display("FAIL wide_rx mode=%0d: got %0d words %h, required %h", m, rxq_b.size(), rxq_b[0], d); end
      model_load(1, e);
    end
    push_tx(1, 16'($urandom_range(0, 4095)));
    frame_begin(1, 2'b00);
    model_load(1, e);
    xfer(1, 2'b00, 12, 6, 1'b1, 16'h0FFF, r);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({miso_b, miso_oe_b, tx_ready_b, rx_valid_b, rx_ovr_b, tx_udr_b, busy_b, rx_dt_b} !== {7'b0010000, 12'h000}) begin
      tests_failed++;
      $display("FAIL midword_reset_b: got %b/%h, required 0010000/000",
               {miso_b, miso_oe_b, tx_ready_b, rx_valid_b, rx_ovr_b, tx_udr_b, busy_b}, rx_dt_b);
    end
    tests_run++;
    if ({miso_a, miso_oe_a, tx_ready_a, rx_valid_a, busy_a, rx_dt_a} !== {5'b00100, 8'h00}) begin
      tests_failed++;
      $display("FAIL midword_reset_a: got %b/%h, required 00100/00", {miso_a, miso_oe_a, tx_ready_a, rx_valid_a, busy_a}, rx_dt_a);
    end
    @(negedge clk);
    cs_b = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    txq_a.delete();
    txq_b.delete();
    repeat (4) @(negedge clk);
    rxq_b.delete();
    d = 16'($urandom_range(0, 4095));
    push_tx(1, 16'($urandom_range(0, 4095)));
    frame_begin(1, 2'b11);
    model_load(1, e);
    xfer(1, 2'b11, 12, 12, 1'b1, d, r);
    model_load(1, r[15:0] == 16'hFFFF ? e : e);
    frame_end(1);
    tests_run++;
    if (rxq_b.size() != 1 || rxq_b[0] !== d) begin tests_failed++; $display("FAIL post_reset_rx: got %0d words %h, required %h", rxq_b.size(), rxq_b[0], d); end
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_a = 1'b0; cs_b = 1'b1; spi_mode = 2'b00;
    tx_dt_a = 8'h00; tx_valid_a = 1'b0; rx_ready_a = 1'b0;
    tx_dt_b = 12'h000; tx_valid_b = 1'b0; rx_ready_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_modes();
    test_back_to_back_overrun();
    test_underrun();
    test_abort();
    test_wide_lsb();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
